// File: rtl/vram_arb_pkg.sv
// -----------------------------------------------------------------------------
// vram_arb_pkg
// Shared widths, FIFO sizing and FSM encoding for the VRAM arbiter slice.
// Imported by vram_wr_fifo and vram_arbiter.
// -----------------------------------------------------------------------------
package vram_arb_pkg;

  localparam int ADDR_W     = 14;  // 128x96 framebuffer
  localparam int DATA_W     = 3;   // RGB, one bit per channel
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W    = PTR_W + 1;  // holds 0..FIFO_DEPTH
  localparam int STALL_W    = 16;

  // Encoding chosen so that bit 0 is the RAM enable and bit 1 the RAM write
  // enable: the state flops double as the registered mem_en / mem_we outputs.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    VID  = 2'b01,
    WR   = 2'b11
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// -----------------------------------------------------------------------------
// vram_wr_fifo
// 4-entry in-order write buffer between the pixel writer and the VRAM port.
// The head entry is presented combinationally; pop advances it.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset (flushes FIFO)
//   push, push_addr/data  enqueue one entry (caller guarantees !full)
//   pop                   dequeue the head entry (caller guarantees !empty)
//   head_addr/data        current head entry
//   full, empty, level    occupancy status, level in 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module vram_wr_fifo
  import vram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_addr,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [ADDR_W-1:0]  head_addr,
  output logic [DATA_W-1:0]  head_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level
);

  wr_entry_t          entries [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;

  assign full      = (count == LEVEL_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign level     = count;
  assign head_addr = entries[rd_ptr].addr;
  assign head_data = entries[rd_ptr].data;

  // NOTE: storage has no reset; validity is carried entirely by the pointers
  // and count, so flushing them is enough and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr] <= '{addr: push_addr, data: push_data};
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  // NOTE: every clocked assignment is non-blocking so all flops sample the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;  // idle, or push and pop cancel out
      endcase
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous VRAM between the VGA pixel fetcher and a
// buffered writer. One access per cycle; video reads always win, writes drain
// from a 4-entry FIFO whenever the reader is quiet (the writer may starve).
// Video read latency is 3 cycles: request sampled at edge k, RAM enabled in
// the following cycle, data registered at edge k+2.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   vid_req, vid_addr          pixel fetcher read request / address
//   vid_valid, vid_data        read data strobe / RGB data
//   wr_valid, wr_ready         writer handshake (wr_ready = FIFO not full)
//   wr_addr, wr_data           write address / RGB data
//   mem_en, mem_we             registered RAM enable / write enable
//   mem_addr, mem_wdata        registered RAM address / write data
//   mem_rdata                  RAM read data, one cycle after a read enable
//   fifo_level                 write FIFO occupancy 0..4
//   stall_cnt                  writer stall cycles, saturating
//
// Build option
//   VRAM_ARB_STATS_EN  when defined, stall_cnt counts cycles with
//                      wr_valid && !wr_ready; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module vram_arbiter
  import vram_arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               vid_req,
  input  logic [ADDR_W-1:0]  vid_addr,
  output logic               vid_valid,
  output logic [DATA_W-1:0]  vid_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic [STALL_W-1:0] stall_cnt
);

  state_t             state;
  state_t             next_state;
  logic [ADDR_W-1:0]  addr_d;
  logic [DATA_W-1:0]  wdata_d;
  logic               push;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               rd_pend;

  // Ready comes straight from the registered level: a pop in this cycle only
  // frees a slot as seen by the writer on the next cycle.
  assign wr_ready = !fifo_full;
  assign push     = wr_valid && wr_ready;

  vram_wr_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (wr_addr),
    .push_data (wr_data),
    .pop       (pop),
    .head_addr (head_addr),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Next state depends only on the current requests, not the current state:
  // a pending video request preempts everything.
  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    next_state = IDLE;
    addr_d     = mem_addr;
    wdata_d    = mem_wdata;
    pop        = 1'b0;
    if (vid_req) begin
      next_state = VID;
      addr_d     = vid_addr;
    end else if (!fifo_empty) begin
      next_state = WR;
      addr_d     = head_addr;
      wdata_d    = head_data;
      pop        = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= next_state;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  assign mem_en = state[0];
  assign mem_we = state[1];

  // Read return path: RAM samples the read in the VID cycle, returns data one
  // cycle later, and the data is registered once more toward the fetcher.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend   <= 1'b0;
      vid_valid <= 1'b0;
      vid_data  <= '0;
    end else begin
      rd_pend   <= (state == VID);
      vid_valid <= rd_pend;
      if (rd_pend) vid_data <= mem_rdata;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (wr_valid && !wr_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named as below.
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset.
REQ-004 vid_req  input  1  VGA pixel fetcher read request, sampled every cycle.
REQ-005 vid_addr  input  14  framebuffer address (128x96 pixels).
REQ-006 vid_valid  output  1  read data valid strobe.
REQ-007 vid_data  output  3  RGB pixel read data.
REQ-008 wr_valid  input  1  writer request.
REQ-009 wr_ready  output  1  writer may transfer.
REQ-010 wr_addr  input  14  write address.
REQ-011 wr_data  input  3  write RGB data.
REQ-012 mem_en  output  1  RAM port enable, registered.
REQ-013 mem_we  output  1  RAM write enable, registered.
REQ-014 mem_addr  output  14  RAM address, registered.
REQ-015 mem_wdata  output  3  RAM write data, registered.
REQ-016 mem_rdata  input  3  RAM read data, valid one cycle after mem_en with mem_we=0.
REQ-017 fifo_level  output  3  write FIFO occupancy, 0..4.
REQ-018 stall_cnt  output  16  count of writer stall cycles (see Configuration).

Function
REQ-019 SHALL share one single-port synchronous VRAM between the video reader and the writer, with one access per cycle.
REQ-020 SHALL buffer writes in a 4-entry in-order FIFO; wr_ready = !full, computed without same-cycle pop bypass; a transfer occurs on wr_valid && wr_ready.
REQ-021 FSM states: IDLE (no access), VID (read issued), WR (FIFO head written); the next state is evaluated every cycle.
REQ-022 Transitions: vid_req=1 -> VID, regardless of the current state; else FIFO non-empty -> WR; else IDLE.
REQ-023 VID: mem_en=1, mem_we=0, mem_addr=vid_addr.
REQ-024 WR: mem_en=1, mem_we=1, mem_addr/mem_wdata = FIFO head, FIFO pops.
REQ-025 IDLE: mem_en=0, mem_we=0.
REQ-026 Video read latency SHALL be exactly 3 cycles: vid_req sampled at edge k -> mem_en issued in cycle k+1 -> vid_valid=1, vid_data=mem_rdata registered at edge k+2 (visible in cycle k+3).
REQ-027 Back-to-back vid_req SHALL give back-to-back vid_valid with no bubbles.
REQ-028 Simultaneous push and pop SHALL keep fifo_level unchanged; when full, a pop frees space visible on wr_ready the following cycle.
REQ-029 No read-after-write forwarding: a read to an address with a pending FIFO write SHALL return the old RAM contents.
REQ-030 Writes SHALL reach RAM in acceptance order; while vid_req is held high the writer starves, with no timeout.

Reset
REQ-031 On reset=0 the FSM SHALL enter IDLE, the FIFO SHALL be flushed, and the following outputs SHALL be 0: fifo_level, stall_cnt, vid_valid, vid_data, mem_en, mem_we, mem_addr, mem_wdata.
REQ-032 wr_ready SHALL be 1 during reset; a reset asserted mid-operation SHALL drop any in-flight vid_valid and any queued writes.

Configuration
REQ-033 Macro VRAM_ARB_STATS_EN defined: stall_cnt SHALL increment each cycle where wr_valid=1 and wr_ready=0, saturating at 16'hFFFF.
REQ-034 Macro VRAM_ARB_STATS_EN undefined: the counter SHALL not be synthesised and stall_cnt SHALL be tied to 0.

Structure
REQ-035 Package vram_arb_pkg SHALL hold: address width 14, data width 3, FIFO depth 4, and the FSM state enum (IDLE, VID, WR).
REQ-036 The FIFO SHALL be a sub-module vram_wr_fifo with push/pop/full/empty/level ports; arbitration and FSM stay in vram_arbiter.

Verification
REQ-037 Reset release, then vid_req=1 at addr 0x0005 for 1 cycle with RAM[5]=3'b101 -> vid_valid=1, vid_data=3'b101 exactly 3 cycles later; all other cycles vid_valid=0.
REQ-038 vid_req=0, writer pushes (0x0010, 3'b011) -> mem_we=1 with mem_addr=0x0010 and mem_wdata=3'b011 one cycle later; fifo_level returns 0.
REQ-039 vid_req held 1 for 10 cycles while the writer pushes 6 words -> wr_ready=0 after 4 accepted, no mem_we during the burst; with the macro defined, stall_cnt increments per stalled cycle; the 4 queued writes drain in order once vid_req=0.
REQ-040 Write 3'b111 to 0x0020 queued while vid_req reads 0x0020 (old value 3'b000) -> vid_data=3'b000.
REQ-041 Assert reset while fifo_level=3 and a read is in flight -> fifo_level=0, no vid_valid, no mem_en after release.
REQ-042 Alternating vid_req 1/0 with a full FIFO -> VID and WR interleave cycle by cycle, and writes retire in order.
